// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan read-back decoder.
// Glyphs are stored in {P,G,F,E,D,C,B,A} order, active-low, with P=1.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic {
        st_settle,
        st_hold
    } state_t;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Frame hand-over bus from the scan decoder to its consumer.
// The decoder drives the frame and valid; the consumer drives ready.
interface seg7_scan_decoder_if;
    logic [31:0] frame_digits;
    logic [7:0]  frame_dp;
    logic [7:0]  frame_blank;
    logic [7:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;

    modport master (
        output frame_digits, frame_dp, frame_blank, frame_err,
        output frame_valid, overrun,
        input  frame_ready
    );

    modport slave (
        input  frame_digits, frame_dp, frame_blank, frame_err,
        input  frame_valid, overrun,
        output frame_ready
    );
endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational cathode-to-glyph decode: {digit, dp, blank, err}.
// SEG7_SCAN_HEX_EN enables the A..F glyphs; otherwise they decode as errors.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [7:0] cathode,
    output logic [3:0] digit,
    output logic       dp,
    output logic       blank,
    output logic       err
);

`ifdef SEG7_SCAN_HEX_EN
    localparam int NUM_LEGAL = 16;
`else
    localparam int NUM_LEGAL = 10;
`endif

    always_comb begin
        digit = 4'h0;
        blank = 1'b0;
        err   = 1'b1;
        dp    = ~cathode[7];
        if (cathode[6:0] == SEG_BLANK) begin
            blank = 1'b1;
            err   = 1'b0;
        end else begin
            for (int i = 0; i < NUM_LEGAL; i++) begin
                if (cathode[6:0] == GLYPH[i][6:0]) begin
                    digit = 4'(i);
                    err   = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Read-back decoder for the 8-digit multiplexed seven-segment bus: settles,
// captures and assembles one frame, hands it over with valid/ready. Honours SEG7_SCAN_HEX_EN.
//
// state     | meaning
// st_settle | counting consecutive unchanged input cycles before a capture
// st_hold   | pattern captured; wait for the next input change
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           anode,
    input  logic [7:0]           cathode,
    seg7_scan_decoder_if.master  bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [7:0]  anode_q, cathode_q, anode_p, cathode_p;
    state_t      state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic        capture, changed, onehot_low, write, complete, take;
    logic [2:0]  pos;

    logic [3:0]  dec_digit;
    logic        dec_dp, dec_blank, dec_err;

    logic [NUM_DIGITS-1:0]   seen, seen_nxt;
    logic [4*NUM_DIGITS-1:0] sh_digits, sh_digits_nxt;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_dp_nxt, sh_blank, sh_blank_nxt, sh_err, sh_err_nxt;

    logic [31:0] frame_digits;
    logic [7:0]  frame_dp, frame_blank, frame_err;
    logic        frame_valid, overrun;

    seg7_glyph_decode u_decode (
        .cathode (cathode_q),
        .digit   (dec_digit),
        .dp      (dec_dp),
        .blank   (dec_blank),
        .err     (dec_err)
    );

    // The settle compare works on registered value vs previous registered value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_q   <= 8'hFF;
            cathode_q <= 8'hFF;
            anode_p   <= 8'hFF;
            cathode_p <= 8'hFF;
        end else begin
            anode_q   <= anode;
            cathode_q <= cathode;
            anode_p   <= anode_q;
            cathode_p <= cathode_q;
        end
    end

    assign changed = (anode_q != anode_p) || (cathode_q != cathode_p);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= st_settle;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counter only advances below the terminal value, so it never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            st_settle: begin
                if (changed) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = st_hold;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            st_hold: begin
                if (changed) begin
                    state_nxt = st_settle;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = st_settle;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign onehot_low = $onehot(~anode_q);

    always_comb begin
        pos = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!anode_q[i]) pos = 3'(i);
        end
    end

    assign write = capture && onehot_low;

    always_comb begin
        seen_nxt      = seen;
        sh_digits_nxt = sh_digits;
        sh_dp_nxt     = sh_dp;
        sh_blank_nxt  = sh_blank;
        sh_err_nxt    = sh_err;
        if (write) begin
            seen_nxt[pos]                  = 1'b1;
            sh_digits_nxt[{pos, 2'b00} +: 4] = dec_digit;
            sh_dp_nxt[pos]                 = dec_dp;
            sh_blank_nxt[pos]              = dec_blank;
            sh_err_nxt[pos]                = dec_err;
        end
    end

    assign complete = write && (seen_nxt == '1);
    assign take     = frame_valid && bus.frame_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen      <= '0;
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_err    <= '0;
        end else begin
            seen      <= complete ? '0 : seen_nxt;
            sh_digits <= sh_digits_nxt;
            sh_dp     <= sh_dp_nxt;
            sh_blank  <= sh_blank_nxt;
            sh_err    <= sh_err_nxt;
        end
    end

    // A transfer in the same cycle as a completion frees the slot for the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_digits <= '0;
            frame_dp     <= '0;
            frame_blank  <= '0;
            frame_err    <= '0;
            frame_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else if (complete && (!frame_valid || take)) begin
            frame_digits <= sh_digits_nxt;
            frame_dp     <= sh_dp_nxt;
            frame_blank  <= sh_blank_nxt;
            frame_err    <= sh_err_nxt;
            frame_valid  <= 1'b1;
        end else if (complete) begin
            overrun <= 1'b1;
        end else if (take) begin
            frame_valid <= 1'b0;
        end
    end

    assign bus.frame_digits = frame_digits;
    assign bus.frame_dp     = frame_dp;
    assign bus.frame_blank  = frame_blank;
    assign bus.frame_err    = frame_err;
    assign bus.frame_valid  = frame_valid;
    assign bus.overrun      = overrun;

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Read-back decoder for the eight-digit multiplexed seven-segment bus. Samples the active-low anode and cathode lines, waits for each pattern to settle, and inverts the cathode encoding to a 4-bit digit plus decimal-point, blank and error flags. It assembles one full eight-digit frame and hands it over with a valid/ready handshake. Used for display self-check and board bring-up, in parallel with the display driver.

## Interface
- STABLE_CYCLES, 4: consecutive unchanged cycles required before a sample is accepted (≥1).

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- anode  in  8  AN7..AN0, active-low, synchronous to clk
- cathode  in  8  {P,G,F,E,D,C,B,A}, active-low, synchronous to clk
- frame_digits  out  32  nibble i = digit at AN i
- frame_dp  out  8  bit i = decimal point lit at AN i
- frame_blank  out  8  bit i = segments A..G all off at AN i
- frame_err  out  8  bit i = unrecognised segment pattern at AN i
- frame_valid  out  1  frame held on outputs
- frame_ready  in  1  consumer accepts frame
- overrun  out  1  sticky: frame completed while previous still pending

## Operation
- Input stage: anode/cathode registered once; the compare uses registered value vs previous registered value.
- FSM, two states:
  - SETTLE: counter increments while input unchanged; any change reloads counter to 0. When counter reaches STABLE_CYCLES-1, do one capture and go to HOLD.
  - HOLD: no further captures. Any input change goes to SETTLE with counter 0.
- Capture is valid only if the anode is one-hot-low (exactly one 0). All-ones anode (blanking gap) or multiple lows are ignored, with no state change other than FSM.
- Decode of cathode[6:0]: the 16 hex glyphs map to 0..F. 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (hex values with P=1). 7'h7F gives blank=1, digit=0. Anything else gives err=1, digit=0. dp = ~cathode[7].
- Shadow registers hold per-position digit/dp/blank/err and an 8-bit seen mask. A capture writes position i and sets seen[i]; recapturing a position overwrites it.
- When seen becomes 8'hFF:
  - If frame_valid=0: copy shadow to frame_* and set frame_valid.
  - Else: set overrun; outputs unchanged.
  - In both cases seen clears.
- Handshake: frame_valid and frame_* held stable until frame_valid & frame_ready. A transfer and a new completion in the same cycle loads the new frame and keeps frame_valid=1, with no overrun.
- overrun clears only on rst.

## Timing
- Reset values: state SETTLE, counter 0, seen 0, shadows 0, frame_digits 0, frame_dp 0, frame_blank 0, frame_err 0, frame_valid 0, overrun 0.
- Pin change to capture: 1 cycle register stage + STABLE_CYCLES cycles.
- Last capture to frame_valid: 1 cycle.
- Counter width: $clog2(STABLE_CYCLES+1). The counter saturates and does not wrap.
- rst mid-frame discards partial shadow and pending frame; the next frame starts from an empty seen mask.

## Configuration
- SEG7_SCAN_HEX_EN defined: glyphs A..F decode to 10..15.
- Undefined: those six patterns decode as err=1, digit=0, so only 0..9 are legal.

## Structure
- seg7_pkg: the 16 glyph constants in {P,G,F,E,D,C,B,A} order, blank constant 7'h7F, FSM state enum, digit count 8.
- Sub-module seg7_glyph_decode: combinational cathode[7:0] to {digit, dp, blank, err}. It honours SEG7_SCAN_HEX_EN.

## Test plan
- Scan AN0..AN7 with glyphs 0..7 (C0,F9,A4,B0,99,92,82,F8), each held 10 cycles, frame_ready=1 → frame_digits=32'h76543210, blank=0, err=0, frame_valid pulses 1 cycle.
- AN3 active with cathode 8'h00 (eight with dp) → dp[3]=1, digit 8. Cathode 8'hFF → blank[3]=1. Cathode 8'hFE → err[3]=1.
- Cathode toggles every 2 cycles with STABLE_CYCLES=4 → no capture. Then held 5 cycles → exactly one capture.
- frame_ready=0 across two complete scans → first frame held unchanged and overrun=1. Assert frame_ready → valid drops the next cycle.
- Anode 8'hFC or 8'hFF held → ignored, seen unchanged. Cathode 8'h88 → 4'hA with SEG7_SCAN_HEX_EN, err without.
- rst asserted after 5 of 8 digits → all outputs 0 asynchronously. The full scan that follows produces a correct frame.
